// File: rtl/sync_fifo_128.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_128
//  Purpose  : Single-clock FIFO with registered read data and registered
//             full / empty / almost-full / almost-empty status flags.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_128 #(
  parameter int DATA_WIDTH    = 128,
  parameter int DEPTH         = 1024,
  parameter int ALM_FULL_LVL  = 1020,
  parameter int ALM_EMPTY_LVL = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wren,
  input  logic                  i_rden,
  input  logic [DATA_WIDTH-1:0] i_wrdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_alm_full,
  output logic                  o_alm_empty,
  output logic [DATA_WIDTH-1:0] o_rddata
);

  localparam int ADDR_W = $clog2(DEPTH);
  // One extra bit so the count can represent DEPTH itself.
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ALM_FULL  = CNT_W'(ALM_FULL_LVL);
  localparam logic [CNT_W-1:0] C_ALM_EMPTY = CNT_W'(ALM_EMPTY_LVL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic                  full_q,   empty_q;
  logic                  alm_full_q, alm_empty_q;
  logic [DATA_WIDTH-1:0] rddata_q;

  logic                  w_wr_ok;
  logic                  w_rd_ok;

  // Accept decisions use the registered flags, so a full FIFO still reads
  // and an empty FIFO still writes when both requests arrive together.
  assign w_wr_ok = i_wren & ~full_q;
  assign w_rd_ok = i_rden & ~empty_q;

  // Next-state pointers and occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_wr_ok, w_rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; flags are computed from the next-state count so they
  // move on the same edge as the accepted operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      alm_full_q  <= 1'b0;
      alm_empty_q <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == C_DEPTH);
      empty_q     <= (count_d == '0);
      alm_full_q  <= (count_d >= C_ALM_FULL);
      alm_empty_q <= (count_d <= C_ALM_EMPTY);
    end
  end

  // Storage array; never reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      mem[wr_ptr_q] <= i_wrdata;
    end
  end

  // Registered read port; holds its value when no read is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rddata_q <= '0;
    end else if (w_rd_ok) begin
      rddata_q <= mem[rd_ptr_q];
    end
  end

  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_alm_full  = alm_full_q;
  assign o_alm_empty = alm_empty_q;
  assign o_rddata    = rddata_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_128.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sync_fifo_128
//  Purpose  : Directed self-checking bench for sync_fifo_128.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_128;

  localparam int DW    = 128;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_wren;
  logic          i_rden;
  logic [DW-1:0] i_wrdata;
  logic          o_full;
  logic          o_empty;
  logic          o_alm_full;
  logic          o_alm_empty;
  logic [DW-1:0] o_rddata;

  int n_checks = 0;
  int n_errors = 0;

  // Stream scoreboard state
  logic [DW-1:0] sb_q [$];
  int            sb_cnt;
  logic [DW-1:0] sb_last;
  logic          s_wr, s_rd, s_wok, s_rok;
  logic [DW-1:0] s_data;

  sync_fifo_128 dut (
    .clk         (clk),
    .reset       (reset),
    .i_wren      (i_wren),
    .i_rden      (i_rden),
    .i_wrdata    (i_wrdata),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_alm_full  (o_alm_full),
    .o_alm_empty (o_alm_empty),
    .o_rddata    (o_rddata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of requests, then return the inputs to idle.
  task automatic op(input logic wr, input logic rd, input logic [DW-1:0] d);
    i_wren   = wr;
    i_rden   = rd;
    i_wrdata = d;
    tick();
    i_wren   = 1'b0;
    i_rden   = 1'b0;
    i_wrdata = '0;
  endtask

  task automatic check_reset_flags(input string tag);
    check({tag, "_empty"},     DW'(o_empty),     DW'(1'b1));
    check({tag, "_alm_empty"}, DW'(o_alm_empty), DW'(1'b1));
    check({tag, "_full"},      DW'(o_full),      DW'(1'b0));
    check({tag, "_alm_full"},  DW'(o_alm_full),  DW'(1'b0));
    check({tag, "_rddata"},    o_rddata,         '0);
  endtask

  initial begin
    reset    = 1'b0;
    i_wren   = 1'b0;
    i_rden   = 1'b0;
    i_wrdata = '0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check_reset_flags("rst");
    reset = 1'b1;
    tick();

    // ---------------- ordering ----------------
    op(1'b1, 1'b0, DW'(1));
    check("ord_empty_w1", DW'(o_empty), DW'(1'b0));
    op(1'b1, 1'b0, DW'(2));
    op(1'b1, 1'b0, DW'(3));
    check("ord_alm_empty_c3", DW'(o_alm_empty), DW'(1'b1));
    op(1'b0, 1'b1, '0);
    check("ord_rd1", o_rddata, DW'(1));
    op(1'b0, 1'b1, '0);
    check("ord_rd2", o_rddata, DW'(2));
    check("ord_empty_mid", DW'(o_empty), DW'(1'b0));
    op(1'b0, 1'b1, '0);
    check("ord_rd3", o_rddata, DW'(3));
    check("ord_empty_end", DW'(o_empty), DW'(1'b1));

    // ---------------- underflow ----------------
    op(1'b0, 1'b1, '0);
    check("uf_rddata_hold", o_rddata, DW'(3));
    check("uf_empty", DW'(o_empty), DW'(1'b1));
    op(1'b1, 1'b0, DW'(128'hAA));
    check("uf_wr_empty", DW'(o_empty), DW'(1'b0));
    op(1'b0, 1'b1, '0);
    check("uf_rd_after", o_rddata, DW'(128'hAA));
    check("uf_empty_after", DW'(o_empty), DW'(1'b1));

    // ---------------- simultaneous at count = 5 ----------------
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b0, DW'(32'h100 + i));
      if (i == 3) check("c5_alm_empty_c4", DW'(o_alm_empty), DW'(1'b1));
      if (i == 4) check("c5_alm_empty_c5", DW'(o_alm_empty), DW'(1'b0));
    end
    op(1'b1, 1'b1, DW'(32'h105));
    check("c5_both_rd", o_rddata, DW'(32'h100));
    check("c5_both_alm_empty", DW'(o_alm_empty), DW'(1'b0));
    check("c5_both_empty", DW'(o_empty), DW'(1'b0));
    check("c5_both_full", DW'(o_full), DW'(1'b0));
    for (int i = 1; i <= 5; i++) begin
      op(1'b0, 1'b1, '0);
      check("c5_drain", o_rddata, DW'(32'h100 + i));
      if (i == 1) check("c5_alm_empty_c4b", DW'(o_alm_empty), DW'(1'b1));
    end
    check("c5_empty_end", DW'(o_empty), DW'(1'b1));

    // ---------------- fill to full, overflow ----------------
    for (int i = 0; i < DEPTH; i++) begin
      op(1'b1, 1'b0, DW'(32'h1000 + i));
      if (i == 1018) check("fill_alm_full_1019", DW'(o_alm_full), DW'(1'b0));
      if (i == 1019) check("fill_alm_full_1020", DW'(o_alm_full), DW'(1'b1));
      if (i == 1022) check("fill_full_1023", DW'(o_full), DW'(1'b0));
      if (i == 1023) check("fill_full_1024", DW'(o_full), DW'(1'b1));
    end
    op(1'b1, 1'b0, DW'(128'hDEAD));
    check("ovf_full", DW'(o_full), DW'(1'b1));
    check("ovf_rddata_hold", o_rddata, DW'(128'hAA) == DW'(0) ? '0 : DW'(32'h105));
    // Full + wren + rden: read wins, write dropped
    op(1'b1, 1'b1, DW'(128'hBEEF));
    check("full_both_full", DW'(o_full), DW'(1'b0));
    check("full_both_alm_full", DW'(o_alm_full), DW'(1'b1));
    check("full_both_rd", o_rddata, DW'(32'h1000));
    for (int j = 1; j < DEPTH; j++) begin
      op(1'b0, 1'b1, '0);
      check("fill_drain", o_rddata, DW'(32'h1000 + j));
      if (j == 4) check("drain_alm_full_c1019", DW'(o_alm_full), DW'(1'b0));
    end
    check("drain_empty", DW'(o_empty), DW'(1'b1));
    check("drain_alm_empty", DW'(o_alm_empty), DW'(1'b1));

    // ---------------- empty + wren + rden ----------------
    op(1'b1, 1'b1, DW'(128'h77));
    check("empty_both_empty", DW'(o_empty), DW'(1'b0));
    check("empty_both_rddata", o_rddata, DW'(32'h1000 + DEPTH - 1));
    op(1'b0, 1'b1, '0);
    check("empty_both_rd", o_rddata, DW'(128'h77));
    check("empty_both_empty2", DW'(o_empty), DW'(1'b1));

    // ---------------- streaming with wrap and mid-stream reset ----------------
    sb_q.delete();
    sb_cnt  = 0;
    sb_last = DW'(128'h77);
    for (int i = 0; i < 3000; i++) begin
      s_wr   = (i % 3) != 2;
      s_rd   = (i % 2) == 0;
      s_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      s_wok  = s_wr && (sb_cnt != DEPTH);
      s_rok  = s_rd && (sb_cnt != 0);
      if (s_rok) begin
        sb_last = sb_q.pop_front();
        sb_cnt--;
      end
      if (s_wok) begin
        sb_q.push_back(s_data);
        sb_cnt++;
      end
      op(s_wr, s_rd, s_data);
      check("stream_rddata", o_rddata, sb_last);
      check("stream_empty", DW'(o_empty), DW'(sb_cnt == 0));
      check("stream_alm_empty", DW'(o_alm_empty), DW'(sb_cnt <= 4));
      if (i == 1500) begin
        // Asynchronous reset between clock edges.
        #3;
        reset = 1'b0;
        #1;
        check_reset_flags("midrst");
        tick();
        reset = 1'b1;
        sb_q.delete();
        sb_cnt  = 0;
        sb_last = '0;
      end
    end
    while (sb_cnt > 0) begin
      sb_last = sb_q.pop_front();
      sb_cnt--;
      op(1'b0, 1'b1, '0);
      check("stream_drain", o_rddata, sb_last);
    end
    check("stream_end_empty", DW'(o_empty), DW'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
